// File: rtl/fixed_point_addsub_ctrl.sv
// Request/handshake controller for an external fixed-point add/sub core.
// Define FIXED_POINT_ADDSUB_CTRL_SATURATE_EN to clamp overflowed results.
module fixed_point_addsub_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_a,
  input  logic [DATA_WIDTH-1:0] i_in_b,
  input  logic                  i_in_sub,
  output logic                  o_core_start,
  output logic                  o_core_sub,
  output logic [DATA_WIDTH-1:0] o_core_operandA,
  output logic [DATA_WIDTH-1:0] o_core_operandB,
  input  logic                  i_core_busy,
  input  logic                  i_core_done,
  input  logic                  i_core_overflow,
  input  logic [DATA_WIDTH-1:0] i_core_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_overflow,
  output logic                  o_timeout,
  output logic [7:0]            o_ovf_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] result;

`ifdef FIXED_POINT_ADDSUB_CTRL_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] POS_MAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_MAX =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Clamp direction follows the sign of the latched A operand.
  always_comb begin
    result = i_core_data;
    if (i_core_overflow)
      result = o_core_operandA[DATA_WIDTH-1] ? NEG_MAX : POS_MAX;
  end
`else
  always_comb begin
    result = i_core_data;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      o_in_ready      <= 1'b0;
      o_core_start    <= 1'b0;
      o_core_sub      <= 1'b0;
      o_core_operandA <= '0;
      o_core_operandB <= '0;
      o_out_valid     <= 1'b0;
      o_out_data      <= '0;
      o_out_overflow  <= 1'b0;
      o_timeout       <= 1'b0;
      o_ovf_count     <= '0;
    end else begin
      o_core_start <= 1'b0;
      o_timeout    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_in_valid && o_in_ready) begin
            o_core_operandA <= i_in_a;
            o_core_operandB <= i_in_b;
            o_core_sub      <= i_in_sub;
            o_in_ready      <= 1'b0;
            state           <= ISSUE;
          end else begin
            o_in_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (!i_core_busy) begin
            o_core_start <= 1'b1;
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // A done on the expiry cycle takes priority over the abort.
          if (i_core_done) begin
            o_out_data     <= result;
            o_out_overflow <= i_core_overflow;
            o_out_valid    <= 1'b1;
            if (i_core_overflow && o_ovf_count != 8'hFF)
              o_ovf_count <= o_ovf_count + 8'd1;
            state <= HOLD;
          end else if (cnt == LAST) begin
            o_timeout  <= 1'b1;
            o_in_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fixed_point_addsub_ctrl.md
FIXED_POINT_ADDSUB_CTRL -- requirements
Module: fixed_point_addsub_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width (signed two's complement).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum WAIT-state cycles before abort (>=2).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_in_valid  input  1  upstream request valid.
REQ-006 SHALL have port o_in_ready  output  1  upstream request accepted when high with i_in_valid.
REQ-007 SHALL have ports i_in_a, i_in_b  input  DATA_WIDTH  operands; i_in_sub  input  1  1=A-B, 0=A+B.
REQ-008 SHALL have ports o_core_start  output  1, o_core_sub  output  1, o_core_operandA, o_core_operandB  output  DATA_WIDTH  drive the add/sub core.
REQ-009 SHALL have ports i_core_busy, i_core_done, i_core_overflow  input  1, i_core_data  input  DATA_WIDTH  core status/result.
REQ-010 SHALL have ports o_out_valid  output  1, i_out_ready  input  1, o_out_data  output  DATA_WIDTH, o_out_overflow  output  1  result stream.
REQ-011 SHALL have ports o_timeout  output  1  one-cycle abort pulse; o_ovf_count  output  8  saturating overflow counter.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, HOLD; only one request in flight.
REQ-013 IDLE: o_in_ready=1; on i_in_valid&o_in_ready latch a, b, sub into o_core_operandA/B, o_core_sub; -> ISSUE next cycle.
REQ-014 ISSUE: if i_core_busy=0 assert o_core_start for exactly one cycle and -> WAIT; if busy, hold in ISSUE with o_core_start=0.
REQ-015 o_core_operandA/B and o_core_sub SHALL stay stable from ISSUE until leaving WAIT.
REQ-016 WAIT: on i_core_done=1 capture i_core_data and i_core_overflow into output registers; -> HOLD; o_out_valid=1 from the next cycle.
REQ-017 WAIT: cycle counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES-1 with no i_core_done, pulse o_timeout one cycle, no result emitted, -> IDLE.
REQ-018 i_core_done on the same cycle the counter expires SHALL win: result captured, no o_timeout.
REQ-019 HOLD: o_out_valid, o_out_data, o_out_overflow held stable until i_out_ready=1; then -> IDLE, o_out_valid=0 next cycle.
REQ-020 o_in_ready SHALL be 0 in ISSUE, WAIT, HOLD (no bypass from HOLD to accept).
REQ-021 o_ovf_count SHALL increment by 1 on each captured result with overflow=1, saturating at 255; never wraps.
REQ-022 i_core_done outside WAIT SHALL be ignored.
REQ-023 Request-to-result latency SHALL be 2 cycles plus core latency plus busy stall cycles.

Reset
REQ-024 While i_rst=1: state=IDLE, o_in_ready=0, o_core_start=0, o_core_sub=0, operands=0, o_out_valid=0, o_out_data=0, o_out_overflow=0, o_timeout=0, o_ovf_count=0, WAIT counter=0.
REQ-025 Reset mid-transaction SHALL abort immediately with no o_timeout and no result; o_in_ready=1 first cycle after release.

Configuration
REQ-026 Macro FIXED_POINT_ADDSUB_CTRL_SATURATE_EN defined: on captured overflow, o_out_data = 0x80 (most negative) if latched A MSB=1, else 0x7F (most positive, DATA_WIDTH-scaled); o_out_overflow still 1.
REQ-027 Macro undefined: o_out_data = i_core_data unmodified (wrapped result), o_out_overflow passes core flag.

Verification
REQ-028 A=0x10,B=0x20,sub=0, core done after 3 cycles with data 0x30 -> o_out_valid with 0x30, overflow=0, o_ovf_count=0.
REQ-029 A=0x70,B=0x20,sub=0, core returns 0x90 ovf=1 -> SATURATE_EN: 0x7F, else 0x90; overflow=1; o_ovf_count=1.
REQ-030 A=0x80,B=0x01,sub=1, core returns 0x7F ovf=1 -> SATURATE_EN: 0x80; o_ovf_count increments.
REQ-031 i_core_busy=1 for 5 cycles in ISSUE -> o_core_start low until busy drops, then single-cycle pulse.
REQ-032 core never asserts done -> o_timeout pulse exactly TIMEOUT_CYCLES cycles after WAIT entry, o_out_valid stays 0, o_in_ready=1 next cycle.
REQ-033 i_out_ready=0 for 4 cycles in HOLD, then i_rst=1 during a second WAIT -> data stable during hold; after reset all outputs 0, no o_timeout.
